// File: rtl/cic_interp.sv
// -----------------------------------------------------------------------------
// cic_interp
// Cascaded integrator-comb interpolator. Each low-rate input sample passes
// through N_STAGES comb (differentiator) stages. The result is zero-stuffed by
// R and then runs through N_STAGES integrators, so R output samples come out
// per input sample. All arithmetic is OW-bit two's complement and wraps on
// overflow, because CIC correctness depends on that wrap.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   sig_in     input sample, Nbits+1 bits, two's complement
//   in_valid   sig_in is valid
//   in_ready   block accepts sig_in this cycle
//   sig_out    output sample, OW = Nbits+1+GROWTH bits (registered)
//   out_valid  sig_out is valid (registered)
//   out_ready  downstream accepts sig_out this cycle
// -----------------------------------------------------------------------------
module cic_interp #(
    parameter int Nbits    = 15,
    parameter int N_STAGES = 3,
    parameter int R        = 4,
    parameter int M        = 1,
    parameter int GROWTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [Nbits:0]          sig_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [Nbits+GROWTH:0]   sig_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int OW  = Nbits + 1 + GROWTH;
    localparam int PHW = (R > 1) ? $clog2(R) : 1;
    localparam logic [PHW-1:0] PH_LAST = PHW'(R - 1);

    // phase within the current input period; 0 means "next tick takes an input"
    logic [PHW-1:0] ph_q, ph_d;
    // comb delay lines: [stage][tap], tap 0 is the most recent accepted value
    logic [OW-1:0]  dly_q   [N_STAGES][M];
    logic [OW-1:0]  dly_d   [N_STAGES][M];
    logic [OW-1:0]  integ_q [N_STAGES];
    logic [OW-1:0]  integ_d [N_STAGES];
    logic           out_valid_q, out_valid_d;

    logic [OW-1:0]  c_s [N_STAGES+1];
    logic [OW-1:0]  u_s;
    logic           adv_s;
    logic           tick_s;
    logic           accept_s;

    // Downstream can take a new sample when the output register is empty or
    // is being drained this cycle.
    assign adv_s    = out_ready | ~out_valid_q;
    // During phase 0 a tick needs a fresh input; in the stuffed phases a tick
    // only needs output room, because the comb output is forced to zero.
    assign tick_s   = adv_s & ((ph_q != '0) | in_valid);
    assign accept_s = tick_s & (ph_q == '0);
    assign in_ready = ~rst & (ph_q == '0) & adv_s;

    assign sig_out   = integ_q[N_STAGES-1];
    assign out_valid = out_valid_q;

    // Combinational comb chain plus the zero-stuffing mux in front of the integrators.
    always_comb begin
        c_s[0] = {{GROWTH{sig_in[Nbits]}}, sig_in};
        for (int k = 1; k <= N_STAGES; k++) begin
            c_s[k] = c_s[k-1] - dly_q[k-1][M-1];
        end
        if (accept_s) begin
            u_s = c_s[N_STAGES];
        end else begin
            u_s = '0;
        end
    end

    // Next-state logic for phase, comb delay lines, integrators and out_valid.
    always_comb begin
        ph_d        = ph_q;
        dly_d       = dly_q;
        integ_d     = integ_q;
        out_valid_d = out_valid_q;
        if (tick_s) begin
            // Integrators are pipelined: each stage adds the previous stage's
            // old value, so the chain adds N_STAGES-1 ticks of latency.
            integ_d[0] = integ_q[0] + u_s;
            for (int k = 1; k < N_STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            out_valid_d = 1'b1;
            if (ph_q == PH_LAST) begin
                ph_d = '0;
            end else begin
                ph_d = ph_q + PHW'(1);
            end
            if (accept_s) begin
                for (int k = 0; k < N_STAGES; k++) begin
                    dly_d[k][0] = c_s[k];
                    for (int j = 1; j < M; j++) begin
                        dly_d[k][j] = dly_q[k][j-1];
                    end
                end
            end else begin
                dly_d = dly_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset; reset clears every in-flight sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q        <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < N_STAGES; k++) begin
                integ_q[k] <= '0;
                for (int j = 0; j < M; j++) begin
                    dly_q[k][j] <= '0;
                end
            end
        end else begin
            ph_q        <= ph_d;
            out_valid_q <= out_valid_d;
            for (int k = 0; k < N_STAGES; k++) begin
                integ_q[k] <= integ_d[k];
                for (int j = 0; j < M; j++) begin
                    dly_q[k][j] <= dly_d[k][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_interp.sv
// -----------------------------------------------------------------------------
// tb_cic_interp
// Directed testbench for cic_interp with its default parameters (N=3, R=4, M=1,
// 16-bit in, 20-bit out). The expected outputs come from a hand-computed
// impulse response h[]. The backpressure/starvation phase convolves the
// accepted inputs with h[] to predict the transferred output stream.
// -----------------------------------------------------------------------------
module tb_cic_interp;

    localparam int NB = 15;
    localparam int GR = 4;
    localparam int OW = NB + 1 + GR;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB:0]   sig_in;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] sig_out;
    logic          out_valid;
    logic          out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // impulse response seen on sig_out, tick by tick, after a unit input
    int h [16] = '{0, 0, 1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0, 0, 0, 0};

    cic_interp #(.Nbits(NB), .N_STAGES(3), .R(4), .M(1), .GROWTH(GR)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sig_out   (sig_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic signed [31:0] sx(input logic [OW-1:0] v);
        sx = {{(32-OW){v[OW-1]}}, v};
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_impulse(input string tag);
        for (int t = 0; t < 16; t++) begin
            in_valid = 1'b1;
            sig_in   = (t == 0) ? 16'sd1 : 16'sd0;
            #1;
            check($sformatf("%s_in_ready_%0d", tag, t), {31'b0, in_ready}, ((t % 4) == 0) ? 1 : 0);
            @(posedge clk);
            #1;
            check($sformatf("%s_sig_out_%0d", tag, t), sx(sig_out), h[t]);
            check($sformatf("%s_out_valid_%0d", tag, t), {31'b0, out_valid}, 1);
        end
        in_valid = 1'b0;
        sig_in   = 16'sd0;
    endtask

    task automatic run_dc(input string tag, input int val);
        in_valid = 1'b1;
        sig_in   = 16'(val);
        for (int t = 0; t < 40; t++) begin
            cyc();
            if (t >= 32) begin
                check($sformatf("%s_%0d", tag, t), sx(sig_out), val * 16);
            end
        end
    endtask

    int    xq[$];
    int    k_out;
    int    nx;
    int    y;
    logic  hold_chk;
    logic [OW-1:0] held;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sig_in    = 16'sd0;

        // Reset and idle
        repeat (3) cyc();
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_sig_out", sx(sig_out), 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'b0, in_ready}, 1);
        cyc();
        cyc();
        check("idle_out_valid", {31'b0, out_valid}, 0);
        check("idle_sig_out", sx(sig_out), 0);

        // Impulse response
        run_impulse("imp1");

        // DC extremes
        run_dc("dc_one", 1);
        run_dc("dc_min", -32768);

        // Deterministic backpressure: output must hold and input must stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        held      = sig_out;
        for (int t = 0; t < 3; t++) begin
            #1;
            check($sformatf("bp_in_ready_%0d", t), {31'b0, in_ready}, 0);
            cyc();
            check($sformatf("bp_hold_%0d", t), sx(sig_out), sx(held));
            check($sformatf("bp_valid_%0d", t), {31'b0, out_valid}, 1);
        end
        out_ready = 1'b1;

        // Mid-stream reset at ph = 2 during an impulse response
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int t = 0; t < 2; t++) begin
            sig_in   = (t == 0) ? 16'sd1 : 16'sd0;
            in_valid = 1'b1;
            cyc();
            check($sformatf("mid_pre_%0d", t), sx(sig_out), h[t]);
        end
        rst      = 1'b1;
        sig_in   = 16'sd5;
        #1;
        check("mid_rst_in_ready", {31'b0, in_ready}, 0);
        cyc();
        check("mid_rst_sig_out", sx(sig_out), 0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        cyc();
        check("mid_post_out_valid", {31'b0, out_valid}, 0);
        check("mid_post_sig_out", sx(sig_out), 0);
        run_impulse("imp2");

        // Random backpressure and starvation with a ramp input
        rst = 1'b1;
        cyc();
        rst   = 1'b0;
        k_out = 0;
        nx    = 0;
        for (int c = 0; c < 400; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            sig_in    = 16'(nx * 37 - 500);
            #1;
            if (out_valid && !out_ready) begin
                check($sformatf("rnd_in_ready_%0d", c), {31'b0, in_ready}, 0);
            end
            if (out_valid && out_ready) begin
                y = 0;
                for (int j = 0; j < xq.size(); j++) begin
                    if ((k_out - 4 * j) >= 0 && (k_out - 4 * j) < 16) begin
                        y += xq[j] * h[k_out - 4 * j];
                    end
                end
                check($sformatf("rnd_out_%0d", k_out), sx(sig_out), sx(OW'(y)));
                k_out++;
            end
            if (in_valid && in_ready) begin
                xq.push_back(int'($signed(sig_in)));
                nx++;
            end
            hold_chk = out_valid & ~out_ready;
            held     = sig_out;
            cyc();
            if (hold_chk) begin
                check($sformatf("rnd_hold_%0d", c), sx(sig_out), sx(held));
            end
        end
        check("rnd_progress", {31'b0, (k_out > 50)}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
